// File: rtl/seq_count_bcd_pkg.sv
// rtl/seq_count_bcd_pkg.sv - shared types and constants for the BCD down counter
package seq_count_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/seq_count_bcd_dec_down_digit.sv
// rtl/seq_count_bcd_dec_down_digit.sv - one combinational BCD digit decrementer with borrow chain
//
// Module bcd_digit_dec
//   digit_in   : current BCD digit (0..9)
//   borrow_in  : 1 when this digit must decrement
//   digit_out  : decremented (or passed-through) digit
//   borrow_out : 1 when this digit wrapped 0 -> 9 and the next digit must decrement
module bcd_digit_dec
    import seq_count_bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    input  logic       borrow_in,
    output bcd_digit_t digit_out,
    output logic       borrow_out
);

    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/seq_count_bcd_dec_down.sv
// rtl/seq_count_bcd_dec_down.sv - multi-digit BCD countdown timer with load, enable and done pulse
//
// Parameters
//   NDIGITS  : number of BCD digits (1..8), count width 4*NDIGITS
// Ports
//   clk      : clock, all state changes on posedge
//   reset    : asynchronous active-high reset
//   load     : load request, highest priority in every state
//   load_val : BCD start value, digit 0 in [3:0]; digits above 9 are clamped to 9
//   en       : count enable, one decrement per cycle while running
//   out      : current BCD count
//   busy     : high while running
//   done     : one-cycle terminal-count pulse
// Build option
//   SEQ_COUNT_BCD_WRAP_EN : when defined, the counter reloads itself after each
//                           done pulse (periodic); otherwise it stops at 0 (one-shot).
module seq_count_bcd_dec_down #(
    parameter int NDIGITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] load_val,
    input  logic                 en,
    output logic [4*NDIGITS-1:0] out,
    output logic                 busy,
    output logic                 done
);
    import seq_count_bcd_pkg::*;

    localparam int W = 4 * NDIGITS;
    localparam logic [W-1:0] COUNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [W-1:0]    out_q, out_d;
    logic [W-1:0]    reload_q, reload_d;
    logic [W-1:0]    load_san;
    logic [W-1:0]    dec_val;
    logic [NDIGITS:0] borrow;
    logic            dec_issue;

    // A decrement is only requested for a nonzero count, so the borrow out of
    // the top digit can never be set.
    assign dec_issue = (state_q == RUN) && en && !load && (out_q != '0);
    assign borrow[0] = dec_issue;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        assign load_san[4*g +: 4] = (load_val[4*g +: 4] > BCD_MAX) ? BCD_MAX
                                                                   : load_val[4*g +: 4];

        bcd_digit_dec u_dec (
            .digit_in   (out_q[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .digit_out  (dec_val[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    logic unused_top_borrow;
    assign unused_top_borrow = borrow[NDIGITS];

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;

        if (load) begin
            out_d    = load_san;
            reload_d = load_san;
            state_d  = (load_san != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (dec_issue) begin
                        out_d = dec_val;
                        if (out_q == COUNT_ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SEQ_COUNT_BCD_WRAP_EN
                    state_d = RUN;
                    out_d   = reload_q;
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifndef SEQ_COUNT_BCD_WRAP_EN
    // The reload value is still captured so both builds share one register map.
    logic [W-1:0] unused_reload;
    assign unused_reload = reload_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
